// File: rtl/hack_mul_seq_pkg.sv
// Shared definitions for the Hack ALU and the multiply sequencer that borrows it.
package hack_mul_seq_pkg;

  // ALU control word is packed as {zx, nx, zy, ny, f, no}.
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam logic [5:0] ALU_ADD  = 6'b000010;  // x + y
  localparam logic [5:0] ALU_ZERO = 6'b101010;  // constant 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational 16-bit Hack ALU (zx/nx/zy/ny/f/no). Lives beside the sequencer
// in the datapath; the sequencer drives it while busy.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out
);

  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  assign x_z   = zx ? 16'h0000 : x;
  assign x_n   = nx ? ~x_z : x_z;
  assign y_z   = zy ? 16'h0000 : y;
  assign y_n   = ny ? ~y_z : y_z;
  assign f_out = f ? (x_n + y_n) : (x_n & y_n);
  assign out   = no ? ~f_out : f_out;

endmodule

// File: rtl/hack_mul_seq.sv
// Shift-and-add multiplier that uses the external Hack ALU as its only adder.
// Computes the low W bits of a*b; ALU drive depends on state and registers only.
module hack_mul_seq
  import hack_mul_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic         alu_zx,
  output logic         alu_nx,
  output logic         alu_zy,
  output logic         alu_ny,
  output logic         alu_f,
  output logic         alu_no,
  input  logic [W-1:0] alu_out
);

  mul_state_t   state, state_nxt;
  logic [W-1:0] acc;   // running sum
  logic [W-1:0] m;     // multiplicand, doubled each DBL
  logic [W-1:0] q;     // multiplier bits still to consume
  logic [5:0]   ctrl;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers: load operands, capture ALU results, publish product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc <= '0;
            m   <= a;
            q   <= b;
            if (b == '0) product <= '0;
          end
        end
        ST_ADD: acc <= alu_out;
        ST_DBL: begin
          m <= alu_out;
          q <= q >> 1;
          // acc already holds the final sum once no multiplier bits remain.
          if ((q >> 1) == '0) product <= acc;
        end
        default: ;
      endcase
    end
  end

  // Next state plus ALU and status outputs.
  // NOTE: defaults first so no path leaves an output unassigned (no latches).
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    ctrl      = ALU_ZERO;
    alu_x     = '0;
    alu_y     = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (b == '0)  state_nxt = ST_DONE;
          else if (b[0]) state_nxt = ST_ADD;
          else           state_nxt = ST_DBL;
        end
      end
      ST_ADD: begin
        ctrl      = ALU_ADD;
        alu_x     = acc;
        alu_y     = m;
        state_nxt = ST_DBL;
      end
      ST_DBL: begin
        ctrl  = ALU_ADD;
        alu_x = m;
        alu_y = m;
        if (q[W-1:1] == '0) state_nxt = ST_DONE;
        else if (q[1])      state_nxt = ST_ADD;
        else                state_nxt = ST_DBL;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign alu_zx = ctrl[CTRL_ZX];
  assign alu_nx = ctrl[CTRL_NX];
  assign alu_zy = ctrl[CTRL_ZY];
  assign alu_ny = ctrl[CTRL_NY];
  assign alu_f  = ctrl[CTRL_F];
  assign alu_no = ctrl[CTRL_NO];

endmodule

// File: tb/tb_hack_mul_seq.sv
// Bench for hack_mul_seq wired to the Hack ALU. Stimulus pushes the expected
// product and completion cycle; a monitor pops and compares on each done.
module tb_hack_mul_seq;
  import hack_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [15:0] product, alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] prod;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  logic prev_done = 1'b0;
  logic watch_add = 1'b0;
  int   add_seen  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hack_mul_seq #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out)
  );

  hack_alu u_alu (
    .x(alu_x), .y(alu_y),
    .zx(alu_zx), .nx(alu_nx), .zy(alu_zy), .ny(alu_ny), .f(alu_f), .no(alu_no),
    .out(alu_out)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Monitor: compare product and completion cycle on each done pulse, and
  // confirm the sequencer is idle the cycle after.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) begin
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
      end
      if (watch_add && {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} == ALU_ADD)
        add_seen++;
      if (done) begin
        check("done_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("product", int'(product), int'(e.prod));
          check("done_cycle", cyc, e.done_cyc);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Drive one start pulse (called at a negedge); edge 0 is the next posedge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] exp_prod, input int lat);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    e.prod     = exp_prod;
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_product", int'(product), 0);
    check("rst_alu_ctrl", int'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
          int'(ALU_ZERO));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 255 x 5 = 1275, ADD,DBL,DBL,ADD,DBL.
    issue(16'd255, 16'd5, 16'd1275, 5);
    drain(50);
    check("product_held", int'(product), 1275);

    // b = 0: immediate completion, ALU never asked to add.
    add_seen  = 0;
    watch_add = 1'b1;
    issue(16'd1234, 16'd0, 16'd0, 0);
    drain(50);
    watch_add = 1'b0;
    check("zero_no_add", add_seen, 0);

    // Worst case latency.
    issue(16'hFFFF, 16'hFFFF, 16'h0001, 32);
    drain(60);

    // Two's-complement operand: -3 x 7 = -21 (b=7: popcount 3 + msb 2 + 1).
    issue(16'hFFFD, 16'd7, 16'hFFEB, 6);
    drain(50);

    // start while busy is ignored.
    issue(16'd255, 16'd5, 16'd1275, 5);
    a = 16'd9;
    b = 16'd9;
    repeat (4) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    drain(50);
    check("ignored_start_product", int'(product), 1275);
    issue(16'd9, 16'd9, 16'd81, 6);
    drain(50);

    // Asynchronous reset mid-operation aborts with outputs cleared at once.
    a     = 16'd255;
    b     = 16'd5;
    start = 1'b1;
    @(posedge clk);          // edge 0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);          // edge 1
    @(posedge clk);          // edge 2
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_product", int'(product), 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_product", int'(product), 0);

    // Recovery: 3 x 4 = 12 (b=4: popcount 1 + msb 2 + 1).
    issue(16'd3, 16'd4, 16'd12, 4);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d pending", sb.size());
    $fatal(1, "timeout");
  end

endmodule
